// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: start/done handshake and data bus of the BCD-to-binary converter
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary;
  logic                  error;
  modport master (output start, bcd, input busy, done, binary, error);
  modport slave  (input start, bcd, output busy, done, binary, error);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: packed BCD to binary by reverse double dabble, one shift per clock
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic                clk,
  input logic                rst_n,
  bcd_to_binary_seq_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     bcd_q, bcd_d, sh;
  logic [BIN_W-1:0] bin_q, bin_d, bin_sh, binary_q, binary_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, error_q, error_d, bad;
  assign bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};
  // shifted digits that land at 8..15 held an odd-weighted ten; subtract 3 to restore BCD
  always_comb begin
    bad = 1'b0;
    sh  = bcd_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (bus.bcd[4*i+:4] > 4'd9);
      sh[4*i+:4] = (sh[4*i+:4] >= 4'd8) ? sh[4*i+:4] - 4'd3 : sh[4*i+:4];
    end
  end
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    error_d  = error_q;
    binary_d = binary_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bad) begin
          state_d  = DONE;
          done_d   = 1'b1;
          error_d  = 1'b1;
          binary_d = '0;
        end else begin
          state_d = SHIFT;
          bcd_d   = bus.bcd;
          bin_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        bcd_d = sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          error_d  = 1'b0;
          binary_d = bin_sh;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      binary_q <= '0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
      binary_q <= binary_d;
    end
  end
  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.binary = binary_q;
endmodule
